// File: rtl/syn_upcounter_4bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : syn_upcounter_4bit_pkg
// Brief    : Shared widths and control-priority encoding for the 4-bit counters
// Revision : 1.0 - initial release
// ============================================================================
package syn_upcounter_4bit_pkg;

    localparam int CNT_W   = 4;
    localparam int MOD_MAX = 16;

    typedef enum logic [2:0] {
        CTL_CLEAR  = 3'd0,
        CTL_PRESET = 3'd1,
        CTL_LOAD   = 3'd2,
        CTL_COUNT  = 3'd3,
        CTL_HOLD   = 3'd4
    } ctl_e;

    // Resolves the per-edge action: clear > preset > load > count > hold.
    function automatic ctl_e ctl_decode(
        input logic clr_bar,
        input logic pre_bar,
        input logic load,
        input logic cnt_en
    );
        ctl_e v_ctl;
        v_ctl = CTL_HOLD;
        if (!clr_bar)
            v_ctl = CTL_CLEAR;
        else if (!pre_bar)
            v_ctl = CTL_PRESET;
        else if (load)
            v_ctl = CTL_LOAD;
        else if (cnt_en)
            v_ctl = CTL_COUNT;
        return v_ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/syn_upcounter_4bit_jkff_sync.sv
`default_nettype none
// ============================================================================
// Module   : jkff_sync
// Brief    : JK flip-flop with synchronous active-low clear and preset
// Revision : 1.0 - initial release
// ============================================================================
module jkff_sync (
    input  logic clk,
    input  logic clr_bar,
    input  logic pre_bar,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_bar
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!clr_bar) begin
            r_q <= 1'b0;
        end else if (!pre_bar) begin
            r_q <= 1'b1;
        end else begin
            case ({J, K})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign Q     = r_q;
    assign Q_bar = ~r_q;

endmodule
`default_nettype wire

// File: rtl/syn_upcounter_4bit.sv
`default_nettype none
// ============================================================================
// Module   : syn_upcounter_4bit
// Brief    : Cascadable synchronous 4-bit up counter built from JK cells,
//            with preset, parallel load and programmable modulus (2..16)
// Revision : 1.0 - initial release
// ============================================================================
module syn_upcounter_4bit
    import syn_upcounter_4bit_pkg::*;
#(
    parameter int MODULUS = 16
) (
    input  logic clk,
    input  logic clr_bar,
    input  logic pre_bar,
    input  logic load,
    input  logic cnt_en,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q0_bar,
    output logic Q1_bar,
    output logic Q2_bar,
    output logic Q3_bar,
    output logic tc,
    output logic rco
);

    localparam logic [CNT_W-1:0] c_term       = CNT_W'(MODULUS - 1);
    localparam logic [CNT_W:0]   c_modulus    = (CNT_W + 1)'(MODULUS);
    localparam logic             c_force_wrap = (MODULUS < MOD_MAX);

    logic [CNT_W-1:0] w_q;
    logic [CNT_W-1:0] w_q_bar;
    logic [CNT_W-1:0] w_d;
    logic [CNT_W-1:0] w_load_tgt;
    logic [CNT_W-1:0] w_j;
    logic [CNT_W-1:0] w_k;
    logic [CNT_W-1:0] w_carry;
    logic [CNT_W-1:0] w_cell_clr_bar;
    logic             w_tc;
    ctl_e             w_ctl;

    assign w_d        = {D3, D2, D1, D0};
    assign w_load_tgt = ({1'b0, w_d} < c_modulus) ? w_d : '0;
    assign w_tc       = (w_q == c_term);

    // Up-count toggle chain: bit i toggles when enabled and all lower bits are 1.
    assign w_carry[0] = cnt_en;
    generate
        for (genvar i = 1; i < CNT_W; i++) begin : g_chain
            assign w_carry[i] = w_carry[i-1] & w_q[i-1];
        end
    endgenerate

    always_comb begin
        w_j   = '0;
        w_k   = '0;
        w_ctl = ctl_decode(clr_bar, pre_bar, load, cnt_en);
        case (w_ctl)
            CTL_LOAD: begin
                w_j = w_load_tgt;
                w_k = ~w_load_tgt;
            end
            CTL_COUNT: begin
                if (c_force_wrap && w_tc) begin
                    w_k = '1;
                end else begin
                    w_j = w_carry;
                    w_k = w_carry;
                end
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    // Preset lands on MODULUS-1: bits that are 0 in that code are cleared instead.
    generate
        for (genvar i = 0; i < CNT_W; i++) begin : g_bits
            assign w_cell_clr_bar[i] = clr_bar & (pre_bar | c_term[i]);

            jkff_sync u_jkff (
                .clk     (clk),
                .clr_bar (w_cell_clr_bar[i]),
                .pre_bar (pre_bar),
                .J       (w_j[i]),
                .K       (w_k[i]),
                .Q       (w_q[i]),
                .Q_bar   (w_q_bar[i])
            );
        end
    endgenerate

    assign Q0     = w_q[0];
    assign Q1     = w_q[1];
    assign Q2     = w_q[2];
    assign Q3     = w_q[3];
    assign Q0_bar = w_q_bar[0];
    assign Q1_bar = w_q_bar[1];
    assign Q2_bar = w_q_bar[2];
    assign Q3_bar = w_q_bar[3];
    assign tc     = w_tc;
    assign rco    = w_tc & cnt_en;

endmodule
`default_nettype wire

// File: tb/tb_syn_upcounter_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_upcounter_4bit
// Brief    : Directed self-checking bench: modulus-16, modulus-10 and a
//            two-stage decade cascade
// Revision : 1.0 - initial release
// ============================================================================
module tb_syn_upcounter_4bit;

    logic clk = 1'b0;
    always #3 clk = ~clk;

    logic       clr_bar;
    logic       pre16, load16, cnt16;
    logic       pre10, load10, cnt10;
    logic       pre_c, load_c, ce_c;
    logic [3:0] d16, d10, dc;

    wire [3:0] q16, qb16, q10, qb10, qc0, qbc0, qc1, qbc1;
    wire       tc16, rco16, tc10, rco10, tcc0, rcoc0, tcc1, rcoc1;

    int n_checks = 0;
    int n_fail   = 0;

    syn_upcounter_4bit #(.MODULUS(16)) u16 (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre16), .load(load16), .cnt_en(cnt16),
        .D0(d16[0]), .D1(d16[1]), .D2(d16[2]), .D3(d16[3]),
        .Q0(q16[0]), .Q1(q16[1]), .Q2(q16[2]), .Q3(q16[3]),
        .Q0_bar(qb16[0]), .Q1_bar(qb16[1]), .Q2_bar(qb16[2]), .Q3_bar(qb16[3]),
        .tc(tc16), .rco(rco16)
    );

    syn_upcounter_4bit #(.MODULUS(10)) u10 (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre10), .load(load10), .cnt_en(cnt10),
        .D0(d10[0]), .D1(d10[1]), .D2(d10[2]), .D3(d10[3]),
        .Q0(q10[0]), .Q1(q10[1]), .Q2(q10[2]), .Q3(q10[3]),
        .Q0_bar(qb10[0]), .Q1_bar(qb10[1]), .Q2_bar(qb10[2]), .Q3_bar(qb10[3]),
        .tc(tc10), .rco(rco10)
    );

    syn_upcounter_4bit #(.MODULUS(10)) u_c0 (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_c), .load(load_c), .cnt_en(ce_c),
        .D0(dc[0]), .D1(dc[1]), .D2(dc[2]), .D3(dc[3]),
        .Q0(qc0[0]), .Q1(qc0[1]), .Q2(qc0[2]), .Q3(qc0[3]),
        .Q0_bar(qbc0[0]), .Q1_bar(qbc0[1]), .Q2_bar(qbc0[2]), .Q3_bar(qbc0[3]),
        .tc(tcc0), .rco(rcoc0)
    );

    syn_upcounter_4bit #(.MODULUS(10)) u_c1 (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_c), .load(load_c), .cnt_en(rcoc0),
        .D0(dc[0]), .D1(dc[1]), .D2(dc[2]), .D3(dc[3]),
        .Q0(qc1[0]), .Q1(qc1[1]), .Q2(qc1[2]), .Q3(qc1[3]),
        .Q0_bar(qbc1[0]), .Q1_bar(qbc1[1]), .Q2_bar(qbc1[2]), .Q3_bar(qbc1[3]),
        .tc(tcc1), .rco(rcoc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {tc, rco, Q_bar, Q} against the expected count and flags.
    task automatic chk(input string tag,
                       input logic [3:0] q, input logic [3:0] qb,
                       input logic tcv, input logic rcov,
                       input logic [3:0] exp_q, input logic exp_tc, input logic exp_rco);
        logic [9:0] obs, exp;
        obs = {tcv, rcov, qb, q};
        exp = {exp_tc, exp_rco, ~exp_q, exp_q};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed tc,rco,qb,q=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] e;
        clr_bar = 1'b0;
        pre16 = 1'b1; load16 = 1'b0; cnt16 = 1'b1; d16 = 4'h0;
        pre10 = 1'b1; load10 = 1'b0; cnt10 = 1'b0; d10 = 4'h0;
        pre_c = 1'b1; load_c = 1'b0; ce_c  = 1'b0; dc  = 4'h0;

        // Reset
        tick();
        chk("reset_u16", q16, qb16, tc16, rco16, 4'b0000, 1'b0, 1'b0);
        chk("reset_u10", q10, qb10, tc10, rco10, 4'b0000, 1'b0, 1'b0);
        chk("reset_c0",  qc0, qbc0, tcc0, rcoc0, 4'b0000, 1'b0, 1'b0);
        tick();
        clr_bar = 1'b1;

        // Modulus 16: 17 enabled edges run through the full cycle and wrap
        for (int i = 1; i <= 17; i++) begin
            tick();
            e = 4'(i);
            chk("count16", q16, qb16, tc16, rco16, e, (e == 4'hF), (e == 4'hF));
        end
        repeat (4) tick();
        chk("count16_at5", q16, qb16, tc16, rco16, 4'b0101, 1'b0, 1'b0);
        pre16 = 1'b0;
        tick();
        chk("preset16", q16, qb16, tc16, rco16, 4'b1111, 1'b1, 1'b1);
        pre16 = 1'b1;
        tick();
        chk("wrap_after_preset16", q16, qb16, tc16, rco16, 4'b0000, 1'b0, 1'b0);

        load16 = 1'b1; d16 = 4'b1010;
        tick();
        chk("load_over_count16", q16, qb16, tc16, rco16, 4'b1010, 1'b0, 1'b0);
        load16 = 1'b0; cnt16 = 1'b0;
        tick();
        tick();
        chk("hold16", q16, qb16, tc16, rco16, 4'b1010, 1'b0, 1'b0);
        load16 = 1'b1; d16 = 4'b1111;
        tick();
        load16 = 1'b0;
        chk("tc_without_en16", q16, qb16, tc16, rco16, 4'b1111, 1'b1, 1'b0);
        tick();
        chk("hold_terminal16", q16, qb16, tc16, rco16, 4'b1111, 1'b1, 1'b0);

        // Modulus 10: load, count through terminal, wrap, out-of-range load
        cnt10 = 1'b1; load10 = 1'b1; d10 = 4'b0111;
        tick();
        chk("load10_0111", q10, qb10, tc10, rco10, 4'b0111, 1'b0, 1'b0);
        load10 = 1'b0;
        tick();
        chk("count10_1000", q10, qb10, tc10, rco10, 4'b1000, 1'b0, 1'b0);
        tick();
        chk("count10_1001", q10, qb10, tc10, rco10, 4'b1001, 1'b1, 1'b1);
        tick();
        chk("wrap10", q10, qb10, tc10, rco10, 4'b0000, 1'b0, 1'b0);
        load10 = 1'b1; d10 = 4'b1100;
        tick();
        chk("load10_oor_1100", q10, qb10, tc10, rco10, 4'b0000, 1'b0, 1'b0);
        d10 = 4'b1001;
        tick();
        chk("load10_max_1001", q10, qb10, tc10, rco10, 4'b1001, 1'b1, 1'b1);
        d10 = 4'b1010;
        tick();
        chk("load10_oor_1010", q10, qb10, tc10, rco10, 4'b0000, 1'b0, 1'b0);
        load10 = 1'b0; cnt10 = 1'b0; pre10 = 1'b0;
        tick();
        chk("preset10", q10, qb10, tc10, rco10, 4'b1001, 1'b1, 1'b0);
        pre10 = 1'b1;

        // Priority between simultaneous controls
        load10 = 1'b1; d10 = 4'b0011;
        tick();
        chk("load10_0011", q10, qb10, tc10, rco10, 4'b0011, 1'b0, 1'b0);
        clr_bar = 1'b0; pre10 = 1'b0; pre16 = 1'b0; load16 = 1'b1; d16 = 4'b0011;
        tick();
        chk("clr_over_all10", q10, qb10, tc10, rco10, 4'b0000, 1'b0, 1'b0);
        chk("clr_over_all16", q16, qb16, tc16, rco16, 4'b0000, 1'b0, 1'b0);
        clr_bar = 1'b1;
        tick();
        chk("pre_over_load10", q10, qb10, tc10, rco10, 4'b1001, 1'b1, 1'b0);
        chk("pre_over_load16", q16, qb16, tc16, rco16, 4'b1111, 1'b1, 1'b0);

        // Single-edge clear in the middle of counting, then resume from 0
        pre10 = 1'b1; load10 = 1'b0; pre16 = 1'b1; load16 = 1'b0;
        cnt16 = 1'b1; clr_bar = 1'b0;
        tick();
        chk("mid_clear16", q16, qb16, tc16, rco16, 4'b0000, 1'b0, 1'b0);
        clr_bar = 1'b1;
        tick();
        chk("resume16", q16, qb16, tc16, rco16, 4'b0001, 1'b0, 1'b0);

        // Two-stage decade cascade: 25 enabled edges from reset
        cnt16 = 1'b0; clr_bar = 1'b0;
        tick();
        clr_bar = 1'b1; ce_c = 1'b1;
        repeat (9) tick();
        chk("cascade9_c0", qc0, qbc0, tcc0, rcoc0, 4'b1001, 1'b1, 1'b1);
        chk("cascade9_c1", qc1, qbc1, tcc1, rcoc1, 4'b0000, 1'b0, 1'b0);
        repeat (16) tick();
        ce_c = 1'b0;
        #1;
        chk("cascade25_c0", qc0, qbc0, tcc0, rcoc0, 4'b0101, 1'b0, 1'b0);
        chk("cascade25_c1", qc1, qbc1, tcc1, rcoc1, 4'b0010, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
